bus_mux_reg: RTL and testbench

- Parametrised, registered shared-datapath bus multiplexer. Successor to the fixed 24-source combinational bus.
- Selects one of NSRC WIDTH-bit sources by one-hot-intended enables, using a lowest-index-wins priority. The selection is registered, so the bus output has a fixed 1-cycle latency.
- Adds idle hold-last behaviour, a stall input, conflict detection with a sticky flag and a saturating counter, and a source-index readback for debug and control.

---
 rtl/bus_pkg.sv | 36 +++
 rtl/bus_mux_reg_prio_encoder.sv | 27 ++
 rtl/bus_mux_reg.sv | 124 ++++++++++++
 tb/tb_bus_mux_reg.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared constants for the processor datapath bus: its dimensions and the
// index assigned to each source that can drive it.
package bus_pkg;

  localparam int BUS_WIDTH = 32;
  localparam int BUS_NSRC  = 24;
  localparam int SEL_W     = $clog2(BUS_NSRC);

  typedef logic [SEL_W-1:0] src_idx_t;

  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_C      = 23;

endpackage

// File: rtl/bus_mux_reg_prio_encoder.sv
// Combinational lowest-index-wins priority encoder that also reports whether
// any request is present and whether more than one is present.
module prio_encoder #(
  parameter int N = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o,
  output logic          multi_o
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  // Scanning downwards lets the lowest set bit make the final assignment.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end

  // Clearing the lowest set bit leaves something behind only if two or more were set.
  assign any_o   = |req_i;
  assign multi_o = |(req_i & (req_i - ONE));

endmodule

// File: rtl/bus_mux_reg.sv
// Registered shared-bus multiplexer with conflict tracking and source readback.
// Define BUS_MUX_PARITY_EN to add the registered bus_parity output.
module bus_mux_reg
  import bus_pkg::*;
#(
  parameter int WIDTH     = BUS_WIDTH,
  parameter int NSRC      = BUS_NSRC,
  parameter bit HOLD_LAST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [NSRC*WIDTH-1:0]   src_data,
  input  logic [NSRC-1:0]         src_en,
  input  logic                    hold,
  input  logic                    conflict_clr,
  output logic [WIDTH-1:0]        bus_out,
  output logic                    bus_valid,
  output logic [$clog2(NSRC)-1:0] sel_idx,
  output logic                    conflict,
  output logic                    conflict_sticky,
`ifdef BUS_MUX_PARITY_EN
  output logic                    bus_parity,
`endif
  output logic [CNT_W-1:0]        conflict_count
);

  localparam int SW = $clog2(NSRC);

  logic [SW-1:0]    encIdx;
  logic             encAny;
  logic             encMulti;
  logic [WIDTH-1:0] selData;
  logic             newConflict;

  logic [WIDTH-1:0] bus_q, bus_d;
  logic             valid_q, valid_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic             conflict_q, conflict_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q, count_d;
`ifdef BUS_MUX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  prio_encoder #(.N(NSRC)) u_enc (
    .req_i   (src_en),
    .idx_o   (encIdx),
    .any_o   (encAny),
    .multi_o (encMulti)
  );

  assign selData     = src_data[int'(encIdx)*WIDTH +: WIDTH];
  assign newConflict = !hold && encMulti;

  always_comb begin
    bus_d      = bus_q;
    valid_d    = valid_q;
    sel_d      = sel_q;
    conflict_d = conflict_q;
    if (!hold) begin
      conflict_d = encMulti;
      if (encAny) begin
        bus_d   = selData;
        sel_d   = encIdx;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
        if (!HOLD_LAST) bus_d = '0;
      end
    end
  end

  // A conflict arriving with conflict_clr takes precedence, so the clear
  // leaves the counter at one rather than zero.
  always_comb begin
    count_d  = count_q;
    sticky_d = newConflict | (sticky_q & !conflict_clr);
    if (conflict_clr) begin
      count_d = newConflict ? CNT_W'(1) : '0;
    end else if (newConflict && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

`ifdef BUS_MUX_PARITY_EN
  assign parity_d = ^bus_d;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bus_q      <= '0;
      valid_q    <= 1'b0;
      sel_q      <= '0;
      conflict_q <= 1'b0;
      sticky_q   <= 1'b0;
      count_q    <= '0;
`ifdef BUS_MUX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      bus_q      <= bus_d;
      valid_q    <= valid_d;
      sel_q      <= sel_d;
      conflict_q <= conflict_d;
      sticky_q   <= sticky_d;
      count_q    <= count_d;
`ifdef BUS_MUX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign bus_out         = bus_q;
  assign bus_valid       = valid_q;
  assign sel_idx         = sel_q;
  assign conflict        = conflict_q;
  assign conflict_sticky = sticky_q;
  assign conflict_count  = count_q;
`ifdef BUS_MUX_PARITY_EN
  assign bus_parity      = parity_q;
`endif

endmodule

// File: tb/tb_bus_mux_reg.sv
// Bench for bus_mux_reg: directed scenarios then random traffic, checked
// against a behavioural model for a HOLD_LAST=1 and a HOLD_LAST=0 instance.
module tb_bus_mux_reg;
  import bus_pkg::*;

  localparam int W = 32;
  localparam int N = 24;

  logic         clk = 1'b0;
  logic         clr;
  logic [N*W-1:0] srcData;
  logic [N-1:0] srcEn;
  logic         hold;
  logic         conflictClr;

  logic [W-1:0] busOutA, busOutB;
  logic         validA, validB;
  logic [4:0]   selA, selB;
  logic         confA, confB;
  logic         stickyA, stickyB;
  logic [7:0]   countA;
  logic [3:0]   countB;
`ifdef BUS_MUX_PARITY_EN
  logic         parityA, parityB;
`endif

  int totalChecks = 0;
  int badChecks   = 0;

  // Model state, index 0 = HOLD_LAST=1/CNT_W=8, index 1 = HOLD_LAST=0/CNT_W=4.
  logic [W-1:0] mBus[2];
  logic         mValid[2];
  int           mSel[2];
  logic         mConf[2];
  logic         mSticky[2];
  int           mCount[2];
  int           cntMax[2] = '{255, 15};
  bit           holdLast[2] = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  bus_mux_reg #(.WIDTH(W), .NSRC(N), .HOLD_LAST(1'b1), .CNT_W(8)) dut (
    .clk(clk), .clr(clr), .src_data(srcData), .src_en(srcEn), .hold(hold),
    .conflict_clr(conflictClr), .bus_out(busOutA), .bus_valid(validA),
    .sel_idx(selA), .conflict(confA), .conflict_sticky(stickyA),
`ifdef BUS_MUX_PARITY_EN
    .bus_parity(parityA),
`endif
    .conflict_count(countA)
  );

  bus_mux_reg #(.WIDTH(W), .NSRC(N), .HOLD_LAST(1'b0), .CNT_W(4)) dut0 (
    .clk(clk), .clr(clr), .src_data(srcData), .src_en(srcEn), .hold(hold),
    .conflict_clr(conflictClr), .bus_out(busOutB), .bus_valid(validB),
    .sel_idx(selB), .conflict(confB), .conflict_sticky(stickyB),
`ifdef BUS_MUX_PARITY_EN
    .bus_parity(parityB),
`endif
    .conflict_count(countB)
  );

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] getWord(int i);
    return srcData[i*W +: W];
  endfunction

  task automatic setWord(input int i, input logic [W-1:0] v);
    srcData[i*W +: W] = v;
  endtask

  task automatic modelReset();
    for (int c = 0; c < 2; c++) begin
      mBus[c] = '0; mValid[c] = 1'b0; mSel[c] = 0;
      mConf[c] = 1'b0; mSticky[c] = 1'b0; mCount[c] = 0;
    end
  endtask

  // One accepted clock edge, straight from the behavioural rules.
  task automatic modelStep();
    int n, w;
    bit cnf;
    n = $countones(srcEn);
    w = 0;
    for (int i = N - 1; i >= 0; i--) if (srcEn[i]) w = i;
    cnf = !hold && (n > 1);
    for (int c = 0; c < 2; c++) begin
      if (!hold) begin
        mConf[c] = (n > 1);
        if (n > 0) begin
          mBus[c] = getWord(w); mSel[c] = w; mValid[c] = 1'b1;
        end else begin
          mValid[c] = 1'b0;
          if (!holdLast[c]) mBus[c] = '0;
        end
      end
      if (conflictClr) begin
        mCount[c]  = cnf ? 1 : 0;
        mSticky[c] = cnf;
      end else if (cnf) begin
        mSticky[c] = 1'b1;
        if (mCount[c] < cntMax[c]) mCount[c]++;
      end
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".busA"},    busOutA, mBus[0]);
    checkOutput({tag, ".validA"},  W'(validA), W'(mValid[0]));
    checkOutput({tag, ".selA"},    W'(selA), W'(mSel[0]));
    checkOutput({tag, ".confA"},   W'(confA), W'(mConf[0]));
    checkOutput({tag, ".stickyA"}, W'(stickyA), W'(mSticky[0]));
    checkOutput({tag, ".countA"},  W'(countA), W'(mCount[0]));
    checkOutput({tag, ".busB"},    busOutB, mBus[1]);
    checkOutput({tag, ".validB"},  W'(validB), W'(mValid[1]));
    checkOutput({tag, ".selB"},    W'(selB), W'(mSel[1]));
    checkOutput({tag, ".confB"},   W'(confB), W'(mConf[1]));
    checkOutput({tag, ".stickyB"}, W'(stickyB), W'(mSticky[1]));
    checkOutput({tag, ".countB"},  W'(countB), W'(mCount[1]));
`ifdef BUS_MUX_PARITY_EN
    checkOutput({tag, ".parA"}, W'(parityA), W'(^mBus[0]));
    checkOutput({tag, ".parB"}, W'(parityB), W'(^mBus[1]));
`endif
  endtask

  // Called just after a falling edge; drives inputs, takes one rising edge,
  // then compares on the following falling edge.
  task automatic applyStimulus(input string tag, input logic [N-1:0] en,
                               input logic h, input logic cc);
    srcEn = en; hold = h; conflictClr = cc;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll(tag);
  endtask

  // Asynchronous clear pulse placed entirely between two rising edges.
  task automatic pulseClear(input string tag);
    #2 clr = 1'b1;
    #1 modelReset();
    compareAll(tag);
    #1 clr = 1'b0;
  endtask

  initial begin
    clr = 1'b1; srcData = '0; srcEn = '0; hold = 1'b0; conflictClr = 1'b0;
    modelReset();
    #2 compareAll("reset");
    @(negedge clk);
    clr = 1'b0;

    setWord(5, 32'hDEAD_BEEF);
    applyStimulus("src5", N'(1) << 5, 1'b0, 1'b0);
    pulseClear("midclr");
    applyStimulus("after_clr", N'(1) << 5, 1'b0, 1'b0);
    checkOutput("after_clr.bus", busOutA, 32'hDEAD_BEEF);
    checkOutput("after_clr.sel", W'(selA), 32'd5);

    setWord(SRC_PC, 32'h0000_1234);
    applyStimulus("pc", N'(1) << SRC_PC, 1'b0, 1'b0);
    checkOutput("pc.bus", busOutA, 32'h0000_1234);
    checkOutput("pc.sel", W'(selA), 32'd20);
    checkOutput("pc.valid", W'(validA), 32'd1);
    checkOutput("pc.conf", W'(confA), 32'd0);

    setWord(3, 32'hA); setWord(SRC_LO, 32'hB);
    applyStimulus("conf", (N'(1) << 3) | (N'(1) << SRC_LO), 1'b0, 1'b0);
    checkOutput("conf.bus", busOutA, 32'hA);
    checkOutput("conf.sel", W'(selA), 32'd3);
    checkOutput("conf.flag", W'(confA), 32'd1);
    checkOutput("conf.sticky", W'(stickyA), 32'd1);
    checkOutput("conf.count", W'(countA), 32'd1);
    for (int i = 0; i < 300; i++)
      applyStimulus("sat", (N'(1) << 3) | (N'(1) << SRC_LO), 1'b0, 1'b0);
    checkOutput("sat.countA", W'(countA), 32'd255);
    checkOutput("sat.countB", W'(countB), 32'd15);

    setWord(7, 32'h55);
    applyStimulus("pre_idle", N'(1) << 7, 1'b0, 1'b0);
    applyStimulus("idle", '0, 1'b0, 1'b0);
    checkOutput("idle.busA", busOutA, 32'h55);
    checkOutput("idle.validA", W'(validA), 32'd0);
    checkOutput("idle.selA", W'(selA), 32'd7);
    checkOutput("idle.busB", busOutB, 32'h0);
    checkOutput("idle.selB", W'(selB), 32'd7);

    applyStimulus("setwins", (N'(1) << 3) | (N'(1) << SRC_LO), 1'b0, 1'b1);
    checkOutput("setwins.sticky", W'(stickyA), 32'd1);
    checkOutput("setwins.count", W'(countA), 32'd1);

    setWord(2, 32'h22); setWord(9, 32'h99); setWord(12, 32'hCC);
    applyStimulus("src2", N'(1) << 2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus("hold", (N'(1) << 9) | (N'(1) << 12), 1'b1, 1'b0);
    checkOutput("hold.bus", busOutA, 32'h22);
    checkOutput("hold.sel", W'(selA), 32'd2);
    checkOutput("hold.conf", W'(confA), 32'd0);
    checkOutput("hold.count", W'(countA), 32'd1);
    applyStimulus("hold_clr", (N'(1) << 9) | (N'(1) << 12), 1'b1, 1'b1);
    checkOutput("hold_clr.sticky", W'(stickyA), 32'd0);
    checkOutput("hold_clr.count", W'(countA), 32'd0);
    checkOutput("hold_clr.bus", busOutA, 32'h22);

    setWord(4, 32'h7);
    applyStimulus("par7", N'(1) << 4, 1'b0, 1'b0);
    setWord(4, 32'h3);
    applyStimulus("par3", N'(1) << 4, 1'b0, 1'b0);
    checkOutput("par3.bus", busOutA, 32'h3);

    for (int i = 0; i < 500; i++) begin
      logic [N-1:0] en;
      for (int s = 0; s < N; s++) setWord(s, $urandom);
      case ($urandom_range(0, 3))
        0:       en = '0;
        1:       en = N'(1) << $urandom_range(0, N - 1);
        default: en = N'($urandom) & N'($urandom);
      endcase
      applyStimulus("rand", en, ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 59) == 0) pulseClear("rand_clr");
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
